// File: rtl/if_stage.sv
// if_stage: instruction fetch with BTB/2-bit-counter prediction, one-entry skid and redirect handling
// Ports: clk/reset (sync, active-high); imem_* instruction-memory read port;
//   stall_in from ID; redirect/redirect_pc from EX; upd_* BTB training from EX;
//   valid_out, pc_out, pc_plus4_out, ir_out, br_predict_out, tgtaddr_out to the IF/ID latch.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter int          BTB_IDX_W = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] ir_out,
    output logic        br_predict_out,
    output logic [31:0] tgtaddr_out
);
    localparam int N  = 1 << BTB_IDX_W;
    localparam int TW = 30 - BTB_IDX_W;
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ir;
        logic        pred;
        logic [31:0] tgt;
    } ent_t;
    localparam ent_t ENT_RST = '{pc: 32'd0, pc4: 32'd4, ir: NOP_INSTR, pred: 1'b0, tgt: 32'd0};
    state_t state_q, state_d;
    logic [31:0] req_q, req_d, pc_q, pc_d;
    logic valid_q, valid_d;
    ent_t slot_q, slot_d, skid_q, skid_d;
    logic [N-1:0] btb_v_q;
    logic [1:0] btb_ctr_q [N];
    logic [TW-1:0] btb_tag_q [N];
    logic [31:0] btb_tgt_q [N];
    logic [BTB_IDX_W-1:0] ridx, uidx;
    logic hit, taken, uhit, consume;
    logic [31:0] next_pc;
    ent_t fetched;
    assign ridx    = req_q[BTB_IDX_W+1:2];
    assign hit     = btb_v_q[ridx] && btb_tag_q[ridx] == req_q[31:BTB_IDX_W+2];
    assign taken   = hit && btb_ctr_q[ridx][1];
    assign next_pc = taken ? btb_tgt_q[ridx] : req_q + 32'd4;
    assign fetched = '{pc: req_q, pc4: req_q + 32'd4, ir: imem_rdata, pred: taken, tgt: next_pc};
    assign consume = valid_q && !stall_in;
    assign imem_read      = !reset && state_q != HOLD;
    assign imem_address   = req_q;
    assign valid_out      = valid_q;
    assign pc_out         = slot_q.pc;
    assign pc_plus4_out   = slot_q.pc4;
    assign ir_out         = valid_q ? slot_q.ir : NOP_INSTR;
    assign br_predict_out = slot_q.pred;
    assign tgtaddr_out    = slot_q.tgt;
    // HOLD means the skid is occupied, so leaving HOLD is what empties it.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pc_d    = pc_q;
        valid_d = valid_q && !consume;
        slot_d  = slot_q;
        skid_d  = skid_q;
        if (redirect) begin
            valid_d = 1'b0;
            pc_d    = redirect_pc;
            if (state_q == FETCH && !imem_resp) begin
                state_d = DISCARD;
            end else if (state_q != DISCARD || imem_resp) begin
                req_d   = redirect_pc;
                state_d = FETCH;
            end
        end else if (state_q == FETCH && imem_resp) begin
            req_d = next_pc;
            if (!valid_q || consume) begin
                slot_d  = fetched;
                valid_d = 1'b1;
            end else begin
                skid_d  = fetched;
                state_d = HOLD;
            end
        end else if (state_q == HOLD && consume) begin
            slot_d  = skid_q;
            valid_d = 1'b1;
            state_d = FETCH;
        end else if (state_q == DISCARD && imem_resp) begin
            req_d   = pc_q;
            state_d = FETCH;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            req_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            slot_q  <= ENT_RST;
            skid_q  <= ENT_RST;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
            skid_q  <= skid_d;
        end
    end
    assign uidx = upd_pc[BTB_IDX_W+1:2];
    assign uhit = btb_v_q[uidx] && btb_tag_q[uidx] == upd_pc[31:BTB_IDX_W+2];
    // Registered arrays give write-after-read for a same-cycle lookup and update.
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_v_q <= '0;
            for (int i = 0; i < N; i++) btb_ctr_q[i] <= 2'b01;
        end else if (upd_valid) begin
            btb_v_q[uidx]   <= 1'b1;
            btb_ctr_q[uidx] <= !uhit ? (upd_taken ? 2'b10 : 2'b01)
                             : upd_taken ? (btb_ctr_q[uidx] == 2'b11 ? 2'b11 : btb_ctr_q[uidx] + 2'd1)
                             : (btb_ctr_q[uidx] == 2'b00 ? 2'b00 : btb_ctr_q[uidx] - 2'd1);
        end
    end
    always_ff @(posedge clk) begin
        if (upd_valid && !reset) begin
            btb_tag_q[uidx] <= upd_pc[31:BTB_IDX_W+2];
            if (upd_taken) btb_tgt_q[uidx] <= upd_target;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vectors, hand sequences and random traffic against a queue-based fetch model
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        imem_resp = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        valid_out;
    logic [31:0] pc_out, pc_plus4_out, ir_out, tgtaddr_out;
    logic        br_predict_out;

    if_stage dut (
        .clk(clk), .reset(reset),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .stall_in(stall_in), .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .valid_out(valid_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .ir_out(ir_out),
        .br_predict_out(br_predict_out), .tgtaddr_out(tgtaddr_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    int lat = 1;
    int mcnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    // Memory answers lat cycles after a read is first seen; state settles well before the next edge.
    always @(posedge clk) begin
        #2;
        if (reset || !imem_read) begin
            mcnt = 0;
            imem_resp = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end else begin
            mcnt++;
            imem_resp = (mcnt >= lat);
            imem_rdata = imem_resp ? mem_word(imem_address) : 32'hDEAD_BEEF;
            if (imem_resp) mcnt = 0;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] tgt;
        bit          pred;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_addr, m_restart;
    bit          m_disc;
    bit          mb_v[16];
    logic [31:0] mb_tag[16];
    logic [31:0] mb_tgt[16];
    int          mb_ctr[16];

    task automatic model_reset();
        mq.delete();
        m_addr = 32'h60;
        m_restart = 32'h60;
        m_disc = 0;
        for (int i = 0; i < 16; i++) begin
            mb_v[i] = 0;
            mb_ctr[i] = 1;
        end
    endtask

    task automatic model_step();
        int idx, ui;
        bit tk, busy, cons;
        logic [31:0] nxt;
        if (reset) begin
            model_reset();
            return;
        end
        idx = int'((m_addr >> 2) % 32'd16);
        tk = mb_v[idx] && mb_tag[idx] == (m_addr >> 6) && mb_ctr[idx] >= 2;
        nxt = tk ? mb_tgt[idx] : m_addr + 32'd4;
        busy = m_disc || mq.size() < 2;
        cons = mq.size() > 0 && !stall_in;
        if (redirect) begin
            mq.delete();
            if (m_disc) begin
                if (imem_resp) begin
                    m_disc = 0;
                    m_addr = redirect_pc;
                end else m_restart = redirect_pc;
            end else if (busy && !imem_resp) begin
                m_disc = 1;
                m_restart = redirect_pc;
            end else m_addr = redirect_pc;
        end else begin
            if (cons) void'(mq.pop_front());
            if (m_disc) begin
                if (imem_resp) begin
                    m_disc = 0;
                    m_addr = m_restart;
                end
            end else if (busy && imem_resp) begin
                mq.push_back('{pc: m_addr, ir: mem_word(m_addr), tgt: nxt, pred: tk});
                m_addr = nxt;
            end
        end
        if (upd_valid) begin
            ui = int'((upd_pc >> 2) % 32'd16);
            if (mb_v[ui] && mb_tag[ui] == (upd_pc >> 6)) begin
                mb_ctr[ui] = upd_taken ? (mb_ctr[ui] == 3 ? 3 : mb_ctr[ui] + 1)
                                       : (mb_ctr[ui] == 0 ? 0 : mb_ctr[ui] - 1);
            end else begin
                mb_v[ui] = 1;
                mb_tag[ui] = upd_pc >> 6;
                mb_ctr[ui] = upd_taken ? 2 : 1;
            end
            if (upd_taken) mb_tgt[ui] = upd_target;
        end
    endtask

    task automatic check_model();
        ent_t e;
        bit ev, erd;
        logic [162:0] got, exp;
        ev = mq.size() > 0;
        erd = !reset && (m_disc || mq.size() < 2);
        if (ev) e = mq[0];
        else e = '{pc: 32'd0, ir: 32'd0, tgt: 32'd0, pred: 1'b0};
        exp = {ev, ev ? e.ir : 32'h13, e.pc, ev ? e.pc + 32'd4 : 32'd0, e.pred, e.tgt,
               erd, erd ? m_addr : 32'd0};
        got = {valid_out, ir_out, valid_out ? pc_out : 32'd0, valid_out ? pc_plus4_out : 32'd0,
               valid_out ? br_predict_out : 1'b0, valid_out ? tgtaddr_out : 32'd0,
               imem_read, imem_read ? imem_address : 32'd0};
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL model cyc=%0d got=%h exp=%h", cyc_n, got, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input bit rs, input bit st, input bit rd, input logic [31:0] rpc);
        reset = rs;
        stall_in = st;
        redirect = rd;
        redirect_pc = rpc;
        model_step();
        @(negedge clk);
        cyc_n++;
        check_model();
    endtask

    task automatic btb_upd(input logic [31:0] p, input bit t, input logic [31:0] tg);
        upd_valid = 1'b1;
        upd_pc = p;
        upd_taken = t;
        upd_target = tg;
        drive(0, 1, 0, 0);
        upd_valid = 1'b0;
    endtask

    task automatic wait_pc(input logic [31:0] p, input string nm);
        int k = 0;
        while (!(valid_out === 1'b1 && pc_out === p) && k < 40) begin
            drive(0, 0, 0, 0);
            k++;
        end
        n_chk++;
        if (!(valid_out === 1'b1 && pc_out === p)) begin
            n_err++;
            $display("FAIL %s timeout pc_out=%h exp=%h", nm, pc_out, p);
        end
    endtask

    typedef struct {
        bit          rst;
        int          lt;
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        bit          erd;
        logic [31:0] eaddr;
    } vec_t;
    vec_t vt[19];

    initial begin
        vt[0]  = '{0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h60};
        vt[1]  = '{0, 1, 0, 0, 32'h0,   1, 32'h60,  1, 32'h64};
        vt[2]  = '{0, 1, 1, 0, 32'h0,   1, 32'h60,  0, 32'h68};
        vt[3]  = '{0, 1, 1, 0, 32'h0,   1, 32'h60,  0, 32'h68};
        vt[4]  = '{0, 1, 1, 0, 32'h0,   1, 32'h60,  0, 32'h68};
        vt[5]  = '{0, 1, 0, 0, 32'h0,   1, 32'h64,  1, 32'h68};
        vt[6]  = '{0, 1, 0, 0, 32'h0,   1, 32'h68,  1, 32'h6C};
        vt[7]  = '{0, 1, 0, 0, 32'h0,   1, 32'h6C,  1, 32'h70};
        vt[8]  = '{1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0};
        vt[9]  = '{0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h60};
        vt[10] = '{0, 1, 0, 0, 32'h0,   1, 32'h60,  1, 32'h64};
        vt[11] = '{0, 1, 0, 0, 32'h0,   1, 32'h64,  1, 32'h68};
        vt[12] = '{0, 3, 0, 0, 32'h0,   1, 32'h68,  1, 32'h6C};
        vt[13] = '{0, 3, 0, 1, 32'h200, 0, 32'h0,   1, 32'h6C};
        vt[14] = '{0, 3, 0, 0, 32'h0,   0, 32'h0,   1, 32'h6C};
        vt[15] = '{0, 3, 0, 0, 32'h0,   0, 32'h0,   1, 32'h200};
        vt[16] = '{0, 3, 0, 0, 32'h0,   0, 32'h0,   1, 32'h200};
        vt[17] = '{0, 3, 0, 0, 32'h0,   0, 32'h0,   1, 32'h200};
        vt[18] = '{0, 3, 0, 0, 32'h0,   1, 32'h200, 1, 32'h204};

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_ir", ir_out, 32'h13);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_pc4", pc_plus4_out, 32'd4);
        chk("rst_pred", {31'd0, br_predict_out}, 32'd0);
        chk("rst_tgt", tgtaddr_out, 32'd0);
        chk("rst_read", {31'd0, imem_read}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            lat = vt[i].lt;
            drive(vt[i].rst, vt[i].stall, vt[i].redir, vt[i].rpc);
            chk($sformatf("vec%0d_valid", i), {31'd0, valid_out}, {31'd0, vt[i].ev});
            chk($sformatf("vec%0d_read", i), {31'd0, imem_read}, {31'd0, vt[i].erd});
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_pc", i), pc_out, vt[i].epc);
                chk($sformatf("vec%0d_ir", i), ir_out, mem_word(vt[i].epc));
            end else chk($sformatf("vec%0d_nop", i), ir_out, 32'h13);
            if (vt[i].erd) chk($sformatf("vec%0d_addr", i), imem_address, vt[i].eaddr);
        end

        lat = 1;
        repeat (3) drive(0, 1, 0, 0);
        chk("hold_read", {31'd0, imem_read}, 32'd0);
        chk("hold_pc", pc_out, 32'h200);
        drive(0, 1, 1, 32'h300);
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        chk("flush_ir", ir_out, 32'h13);
        for (int k = 0; k < 40 && valid_out !== 1'b1; k++) drive(0, 0, 0, 0);
        chk("flush_first_pc", pc_out, 32'h300);

        btb_upd(32'h80, 1, 32'h100);
        btb_upd(32'h80, 1, 32'h100);
        drive(0, 0, 1, 32'h78);
        wait_pc(32'h80, "btb_taken_wait");
        chk("btb_pred", {31'd0, br_predict_out}, 32'd1);
        chk("btb_tgt", tgtaddr_out, 32'h100);
        chk("btb_next_req", imem_address, 32'h100);
        drive(0, 0, 0, 0);
        chk("btb_next_pc", pc_out, 32'h100);
        btb_upd(32'h80, 0, 32'h0);
        btb_upd(32'h80, 0, 32'h0);
        drive(0, 0, 1, 32'h80);
        wait_pc(32'h80, "btb_nt_wait");
        chk("btb_nt_pred", {31'd0, br_predict_out}, 32'd0);
        chk("btb_nt_tgt", tgtaddr_out, 32'h84);
        chk("btb_nt_req", imem_address, 32'h84);

        drive(0, 0, 1, 32'hFFFF_FFFC);
        wait_pc(32'hFFFF_FFFC, "wrap_wait");
        chk("wrap_pc4", pc_plus4_out, 32'h0);
        chk("wrap_tgt", tgtaddr_out, 32'h0);
        chk("wrap_req", imem_address, 32'h0);
        drive(0, 0, 0, 0);
        chk("wrap_next_pc", pc_out, 32'h0);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] rp;
            lat = $urandom_range(1, 3);
            upd_valid = ($urandom_range(0, 4) == 0);
            upd_pc = 32'($urandom_range(0, 255)) << 2;
            upd_taken = 1'($urandom_range(0, 1));
            upd_target = 32'($urandom_range(0, 255)) << 2;
            rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 255)) << 2;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, rp);
        end
        upd_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
